uram_read_streamer: RTL and testbench

URAM_READ_STREAMER -- requirements
Module: uram_read_streamer

---
 rtl/uram_read_streamer_pkg.sv | 13 +
 rtl/uram_read_streamer_if.sv | 26 ++
 rtl/uram_read_streamer_fifo.sv | 67 ++++++
 rtl/uram_read_streamer.sv | 168 ++++++++++++++++
 tb/tb_uram_read_streamer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uram_read_streamer_pkg.sv
// Shared types and constants for the URAM read streamer and its output FIFO.
package uram_stream_pkg;

  // Width of occupancy / credit counters; FIFO_DEPTH plus in-flight reads must fit.
  localparam int unsigned CREDIT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } stream_state_e;

endpackage

// File: rtl/uram_read_streamer_if.sv
// Command, URAM read port and result stream of the streamer, bundled as one interface.
interface uram_read_streamer_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12
) ();
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ADDRESS_WIDTH-1:0] cmd_base;
  logic [ADDRESS_WIDTH:0]   cmd_count;
  logic [ADDRESS_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0]    mem_dout;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_last;

  modport master (
    input  cmd_valid, cmd_base, cmd_count, mem_dout, out_ready,
    output cmd_ready, mem_raddr, out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_count, mem_dout, out_ready,
    input  cmd_ready, mem_raddr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/uram_read_streamer_fifo.sv
// stream_fifo: synchronous FIFO holding returned words plus their last flag; the head
// entry is presented directly so it stays stable while the consumer stalls.
module stream_fifo
  import uram_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic                valid,
  output logic [CREDIT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [PTR_W-1:0]    head_r;
  logic [PTR_W-1:0]    tail_r;
  logic [CREDIT_W-1:0] count_r;
  logic                pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + PTR_W'(1'b1);
    end
  endfunction

  assign pop_s = rd_en && (count_r != {CREDIT_W{1'b0}});

  // Storage write; contents need no reset since count_r qualifies every read.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[tail_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (wr_en) begin
        tail_r <= next_ptr(tail_r);
      end
      if (pop_s) begin
        head_r <= next_ptr(head_r);
      end
      case ({wr_en, pop_s})
        2'b10:   count_r <= count_r + {{(CREDIT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CREDIT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[head_r];
  assign valid   = (count_r != {CREDIT_W{1'b0}});
  assign count   = count_r;
endmodule

// File: rtl/uram_read_streamer.sv
// uram_read_streamer: reads cmd_count consecutive URAM words from cmd_base and streams
// them out; reads are issued only against free FIFO credit so the buffer never overflows.
module uram_read_streamer
  import uram_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12,
  parameter int READ_LATENCY  = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  uram_read_streamer_if.master bus,
  output logic                 busy
);
  localparam logic [CREDIT_W-1:0]      DEPTH_C    = CREDIT_W'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   COUNT_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH:0]   COUNT_ZERO = {(ADDRESS_WIDTH+1){1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE   = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  stream_state_e             state_r;
  stream_state_e             state_next_s;
  logic                      cmd_ready_r;
  logic [ADDRESS_WIDTH-1:0]  raddr_r;
  logic [ADDRESS_WIDTH:0]    remaining_r;
  logic [READ_LATENCY-1:0]   tag_valid_r;
  logic [READ_LATENCY-1:0]   tag_last_r;
  logic                      ret_valid_r;
  logic [DATA_WIDTH:0]       ret_word_r;
  logic                      accept_s;
  logic                      issue_s;
  logic                      last_issue_s;
  logic                      pop_s;
  logic                      done_s;
  logic [CREDIT_W-1:0]       inflight_s;
  logic [CREDIT_W-1:0]       occupancy_s;
  logic [CREDIT_W-1:0]       fifo_count_s;
  logic                      fifo_valid_s;
  logic [DATA_WIDTH:0]       fifo_word_s;

  assign accept_s = bus.cmd_valid && cmd_ready_r;
  assign pop_s    = fifo_valid_s && bus.out_ready;
  assign done_s   = pop_s && fifo_word_s[DATA_WIDTH];

  // Credit: tags in the latency pipe, the capture stage and FIFO entries, minus this cycle's pop.
  always_comb begin
    inflight_s = {{(CREDIT_W-1){1'b0}}, ret_valid_r};
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_s = inflight_s + {{(CREDIT_W-1){1'b0}}, tag_valid_r[i]};
    end
    occupancy_s = inflight_s + fifo_count_s - {{(CREDIT_W-1){1'b0}}, pop_s};
  end

  // FSM state register; cmd_ready tracks the next state so it is low while in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cmd_ready_r <= (state_next_s == IDLE);
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (bus.cmd_count != COUNT_ZERO)) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (last_issue_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = ISSUE;
        end
      end
      DRAIN: begin
        if (done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: a read issues on the address currently presented when credit allows.
  always_comb begin
    issue_s      = 1'b0;
    last_issue_s = 1'b0;
    case (state_r)
      ISSUE: begin
        issue_s      = (occupancy_s < DEPTH_C);
        last_issue_s = issue_s && (remaining_r == COUNT_ONE);
      end
      default: begin
        issue_s      = 1'b0;
        last_issue_s = 1'b0;
      end
    endcase
  end

  // Address and remaining-word counters; the address holds on stall and after the last read.
  always_ff @(posedge clock) begin
    if (reset) begin
      raddr_r     <= '0;
      remaining_r <= '0;
    end else if (accept_s) begin
      raddr_r     <= bus.cmd_base;
      remaining_r <= bus.cmd_count;
    end else if (issue_s) begin
      remaining_r <= remaining_r - COUNT_ONE;
      if (!last_issue_s) begin
        raddr_r <= raddr_r + ADDR_ONE;
      end
    end else begin
      raddr_r     <= raddr_r;
      remaining_r <= remaining_r;
    end
  end

  // Tag pipe aligned with URAM latency, then a capture stage feeding the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid_r <= '0;
      tag_last_r  <= '0;
      ret_valid_r <= 1'b0;
      ret_word_r  <= '0;
    end else begin
      tag_valid_r[0] <= issue_s;
      tag_last_r[0]  <= last_issue_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
        tag_last_r[i]  <= tag_last_r[i-1];
      end
      ret_valid_r <= tag_valid_r[READ_LATENCY-1];
      ret_word_r  <= {tag_last_r[READ_LATENCY-1], bus.mem_dout};
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (ret_valid_r),
    .wr_data (ret_word_r),
    .rd_en   (pop_s),
    .rd_data (fifo_word_s),
    .valid   (fifo_valid_s),
    .count   (fifo_count_s)
  );

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.mem_raddr = raddr_r;
  assign bus.out_valid = fifo_valid_s;
  assign bus.out_data  = fifo_word_s[DATA_WIDTH-1:0];
  assign bus.out_last  = fifo_valid_s && fifo_word_s[DATA_WIDTH];
  assign busy          = (state_r != IDLE);
endmodule

// File: tb/tb_uram_read_streamer.sv
// Self-checking bench for uram_read_streamer: URAM models with latency 2 and 1, and a
// scoreboard queue of expected {last, data} words compared as the stream delivers them.
module tb_uram_read_streamer;
  import uram_stream_pkg::*;

  logic clock;
  logic reset;
  logic busy_a;
  logic busy_b;
  int   checks = 0;
  int   passed = 0;
  logic [64:0] sb[$];

  uram_read_streamer_if #(.DATA_WIDTH(64), .ADDRESS_WIDTH(12)) bus_a ();
  uram_read_streamer_if #(.DATA_WIDTH(64), .ADDRESS_WIDTH(12)) bus_b ();

  uram_read_streamer #(.DATA_WIDTH(64), .ADDRESS_WIDTH(12), .READ_LATENCY(2), .FIFO_DEPTH(4))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a), .busy(busy_a));
  uram_read_streamer #(.DATA_WIDTH(64), .ADDRESS_WIDTH(12), .READ_LATENCY(1), .FIFO_DEPTH(4))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b), .busy(busy_b));

  function automatic logic [63:0] word_of(input logic [11:0] a);
    return {20'hC0DE0, a, 20'h5EED0, ~a};
  endfunction

  // URAM models: dout follows raddr by 2 cycles (bus_a) and 1 cycle (bus_b).
  logic [63:0] a_d1, a_d2, b_d1;
  always @(posedge clock) begin
    a_d1 <= word_of(bus_a.mem_raddr);
    a_d2 <= a_d1;
    b_d1 <= word_of(bus_b.mem_raddr);
  end
  assign bus_a.mem_dout = a_d2;
  assign bus_b.mem_dout = b_d1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_words(input logic [11:0] base, input int count);
    logic [11:0] a = base;
    for (int i = 0; i < count; i++) begin
      sb.push_back({(i == count - 1) ? 1'b1 : 1'b0, word_of(a)});
      a = a + 12'd1;
    end
  endtask

  // Presents a command on bus_a; returns just after the accepting edge.
  task automatic send_a(input logic [11:0] base, input logic [12:0] count);
    bit ok = 1'b0;
    bus_a.cmd_base  = base;
    bus_a.cmd_count = count;
    bus_a.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus_a.cmd_ready === 1'b1) ok = 1'b1;
      step();
    end
    bus_a.cmd_valid = 1'b0;
    checks++;
    if (!ok) $display("FAIL cmd_accept: cmd_ready stayed %b, required 1 (base %h)", bus_a.cmd_ready, base);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({bus_a.cmd_ready, bus_a.out_valid, bus_a.out_last, busy_a} !== 4'b0000)
      $display("FAIL reset_ctrl_a: rdy/vld/last/busy=%b required 0000",
               {bus_a.cmd_ready, bus_a.out_valid, bus_a.out_last, busy_a});
    else passed++;
    checks++;
    if (bus_a.mem_raddr !== 12'h000) $display("FAIL reset_raddr: got %h required 000", bus_a.mem_raddr);
    else passed++;
    checks++;
    if ({bus_b.cmd_ready, bus_b.out_valid, bus_b.out_last, busy_b, bus_b.mem_raddr} !== 16'h0000)
      $display("FAIL reset_b: got %h required 0000",
               {bus_b.cmd_ready, bus_b.out_valid, bus_b.out_last, busy_b, bus_b.mem_raddr});
    else passed++;
    reset = 1'b0;
    step();
    checks++;
    if ({bus_a.cmd_ready, bus_b.cmd_ready} !== 2'b11)
      $display("FAIL reset_release_ready: got %b required 11", {bus_a.cmd_ready, bus_b.cmd_ready});
    else passed++;
  endtask

  task automatic test_basic();
    logic [64:0] e;
    int got = 0;
    int first_n = -1;
    sb.delete();
    bus_a.out_ready = 1'b1;
    expect_words(12'h010, 4);
    send_a(12'h010, 13'd4);
    for (int n = 1; n <= 40 && got < 4; n++) begin
      step();
      if (bus_a.out_valid && first_n < 0) first_n = n;
      if (bus_a.out_valid && bus_a.out_ready) begin
        e = sb.pop_front();
        checks++;
        if ({bus_a.out_last, bus_a.out_data} !== e)
          $display("FAIL basic_word%0d: got %h required %h", got, {bus_a.out_last, bus_a.out_data}, e);
        else passed++;
        got++;
      end
    end
    checks++;
    if (first_n != 4) $display("FAIL basic_latency: first out_valid at +%0d required +4", first_n);
    else passed++;
    checks++;
    if (got != 4) $display("FAIL basic_count: got %0d words required 4", got);
    else passed++;
    step();
    checks++;
    if ({busy_a, bus_a.out_valid, bus_a.cmd_ready} !== 3'b001)
      $display("FAIL basic_done: busy/vld/rdy=%b required 001", {busy_a, bus_a.out_valid, bus_a.cmd_ready});
    else passed++;
  endtask

  task automatic test_wrap();
    logic [64:0] e;
    logic [11:0] addr_q[$];
    logic [11:0] exp_addr[4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    int got = 0;
    sb.delete();
    bus_a.out_ready = 1'b1;
    expect_words(12'hFFE, 4);
    send_a(12'hFFE, 13'd4);
    addr_q.push_back(bus_a.mem_raddr);
    for (int n = 1; n <= 40 && got < 4; n++) begin
      step();
      if (addr_q[$] !== bus_a.mem_raddr) addr_q.push_back(bus_a.mem_raddr);
      if (bus_a.out_valid && bus_a.out_ready) begin
        e = sb.pop_front();
        checks++;
        if ({bus_a.out_last, bus_a.out_data} !== e)
          $display("FAIL wrap_word%0d: got %h required %h", got, {bus_a.out_last, bus_a.out_data}, e);
        else passed++;
        got++;
      end
    end
    checks++;
    if (addr_q.size() != 4) $display("FAIL wrap_addr_count: got %0d addresses required 4", addr_q.size());
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= addr_q.size() || addr_q[i] !== exp_addr[i])
        $display("FAIL wrap_raddr%0d: got %h required %h", i, (i < addr_q.size()) ? addr_q[i] : 12'hxxx, exp_addr[i]);
      else passed++;
    end
    step();
  endtask

  task automatic test_zero_count();
    bit seen = 1'b0;
    send_a(12'h123, 13'd0);
    checks++;
    if ({bus_a.cmd_ready, busy_a} !== 2'b10)
      $display("FAIL zero_ready: rdy/busy=%b required 10", {bus_a.cmd_ready, busy_a});
    else passed++;
    for (int n = 0; n < 8; n++) begin
      step();
      if (bus_a.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL zero_no_output: out_valid seen 1 required 0");
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [64:0] e;
    logic [64:0] held;
    bit holding = 1'b0;
    int got = 0;
    int max_cnt = 0;
    sb.delete();
    bus_a.out_ready = 1'b1;
    expect_words(12'h200, 16);
    send_a(12'h200, 13'd16);
    for (int n = 1; n <= 200 && got < 16; n++) begin
      step();
      bus_a.out_ready = ~bus_a.out_ready;
      if (int'(dut_a.u_fifo.count_r) > max_cnt) max_cnt = int'(dut_a.u_fifo.count_r);
      if (holding) begin
        checks++;
        if ({bus_a.out_valid, bus_a.out_last, bus_a.out_data} !== {1'b1, held})
          $display("FAIL bp_hold_stable: got %h required %h",
                   {bus_a.out_valid, bus_a.out_last, bus_a.out_data}, {1'b1, held});
        else passed++;
        holding = 1'b0;
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        e = sb.pop_front();
        checks++;
        if ({bus_a.out_last, bus_a.out_data} !== e)
          $display("FAIL bp_word%0d: got %h required %h", got, {bus_a.out_last, bus_a.out_data}, e);
        else passed++;
        got++;
      end else if (bus_a.out_valid) begin
        held = {bus_a.out_last, bus_a.out_data};
        holding = 1'b1;
      end
    end
    checks++;
    if (got != 16) $display("FAIL bp_count: got %0d words required 16", got);
    else passed++;
    checks++;
    if (max_cnt > 4) $display("FAIL bp_fifo_level: max %0d required <= 4", max_cnt);
    else passed++;
    step();
    bus_a.out_ready = 1'b1;
    checks++;
    if (busy_a !== 1'b0) $display("FAIL bp_busy: got %b required 0", busy_a);
    else passed++;
  endtask

  task automatic test_reset_abort();
    logic [64:0] e;
    bit seen = 1'b0;
    int got = 0;
    sb.delete();
    bus_a.out_ready = 1'b1;
    send_a(12'h300, 13'd8);
    for (int n = 0; n < 3; n++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (bus_a.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL abort_no_output: out_valid seen 1 required 0");
    else passed++;
    checks++;
    if ({busy_a, bus_a.cmd_ready} !== 2'b01)
      $display("FAIL abort_idle: busy/rdy=%b required 01", {busy_a, bus_a.cmd_ready});
    else passed++;
    expect_words(12'h040, 2);
    send_a(12'h040, 13'd2);
    for (int n = 1; n <= 40; n++) begin
      step();
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL abort_extra_word: got %h required none", {bus_a.out_last, bus_a.out_data});
        end else begin
          e = sb.pop_front();
          checks++;
          if ({bus_a.out_last, bus_a.out_data} !== e)
            $display("FAIL abort_word%0d: got %h required %h", got, {bus_a.out_last, bus_a.out_data}, e);
          else passed++;
        end
        got++;
      end
    end
    checks++;
    if (got != 2) $display("FAIL abort_count: got %0d words required 2", got);
    else passed++;
  endtask

  task automatic test_latency1();
    logic [64:0] e;
    bit ok = 1'b0;
    int got = 0;
    int first_n = -1;
    sb.delete();
    bus_b.out_ready = 1'b1;
    expect_words(12'h055, 1);
    bus_b.cmd_base  = 12'h055;
    bus_b.cmd_count = 13'd1;
    bus_b.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus_b.cmd_ready === 1'b1) ok = 1'b1;
      step();
    end
    bus_b.cmd_valid = 1'b0;
    checks++;
    if (!ok) $display("FAIL lat1_accept: cmd_ready stayed %b required 1", bus_b.cmd_ready);
    else passed++;
    for (int n = 1; n <= 20 && got < 1; n++) begin
      step();
      if (bus_b.out_valid && first_n < 0) first_n = n;
      if (bus_b.out_valid && bus_b.out_ready) begin
        e = sb.pop_front();
        checks++;
        if ({bus_b.out_last, bus_b.out_data} !== e)
          $display("FAIL lat1_word: got %h required %h", {bus_b.out_last, bus_b.out_data}, e);
        else passed++;
        got++;
      end
    end
    checks++;
    if (first_n != 3) $display("FAIL lat1_latency: first out_valid at +%0d required +3", first_n);
    else passed++;
    step();
    checks++;
    if ({busy_b, bus_b.out_valid} !== 2'b00)
      $display("FAIL lat1_done: busy/vld=%b required 00", {busy_b, bus_b.out_valid});
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    bus_a.cmd_valid = 1'b0;
    bus_a.cmd_base  = 12'h000;
    bus_a.cmd_count = 13'd0;
    bus_a.out_ready = 1'b1;
    bus_b.cmd_valid = 1'b0;
    bus_b.cmd_base  = 12'h000;
    bus_b.cmd_count = 13'd0;
    bus_b.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_count();
    test_backpressure();
    test_reset_abort();
    test_latency1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
